// File: rtl/arb_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, port indices, latched op and a
// port-index-to-one-hot helper.
package arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

  localparam logic P_IFETCH = 1'b0;
  localparam logic P_DATA   = 1'b1;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  function automatic logic [1:0] port_onehot(logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals around the arbiter.
// The arbiter uses the slave modport; whoever drives requests and the SRAM uses master.
interface sram_arbiter_if;

  logic [1:0]  req_r_en;
  logic [1:0]  req_w_en;
  logic [31:0] req0_addr;
  logic [31:0] req1_addr;
  logic [31:0] req0_wdata;
  logic [31:0] req1_wdata;
  logic [1:0]  req_ready;
  logic [63:0] req_rdata;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  modport slave (
    input  req_r_en, req_w_en, req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  sram_rdata, sram_ready,
    output req_ready, req_rdata, sram_addr, sram_wdata, sram_r_en, sram_w_en,
    output grant, timeout_err
  );

  modport master (
    output req_r_en, req_w_en, req0_addr, req1_addr, req0_wdata, req1_wdata,
    output sram_rdata, sram_ready,
    input  req_ready, req_rdata, sram_addr, sram_wdata, sram_r_en, sram_w_en,
    input  grant, timeout_err
  );

endinterface

// File: rtl/rr_picker.sv
// Two-port winner selection: fixed priority to the data port, or round-robin that
// favours the port which did not win last time.
module rr_picker
  import arb_pkg::*;
#(
  parameter bit FixedPrio = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = P_IFETCH;
    case (req_i)
      2'b01:   winner_o = P_IFETCH;
      2'b10:   winner_o = P_DATA;
      2'b11:   winner_o = FixedPrio ? P_DATA : ~last_grant_i;
      default: winner_o = P_IFETCH;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between the instruction-fetch and data ports: picks a
// winner, latches its request, runs one transaction with a watchdog, returns the result.
module sram_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  localparam logic [9:0] CntLast = 10'(TIMEOUT - 1);

  arb_state_e  state_q;
  logic        owner_q;
  logic        last_q;
  arb_op_e     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [9:0]  cnt_q;
  logic        err_q;

  logic [1:0] req;
  logic       pick;
  logic       pick_valid;
  logic       in_busy;
  logic       done;
  logic       tmo_hit;

  assign req = bus.req_r_en | bus.req_w_en;

  rr_picker #(
    .FixedPrio (FIXED_PRIO != 0)
  ) u_picker (
    .req_i        (req),
    .last_grant_i (last_q),
    .winner_o     (pick),
    .valid_o      (pick_valid)
  );

  // cnt_q counts completed BUSY cycles, so CntLast marks the TIMEOUT-th one.
  assign in_busy = (state_q == StBusy);
  assign done    = in_busy && (bus.sram_ready || (cnt_q == CntLast));
  assign tmo_hit = done && !bus.sram_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= P_IFETCH;
      last_q  <= P_DATA;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StRelease: begin
          if (pick_valid) begin
            state_q <= StBusy;
            owner_q <= pick;
            op_q    <= bus.req_w_en[pick] ? OP_WR : OP_RD;
            addr_q  <= pick ? bus.req1_addr : bus.req0_addr;
            wdata_q <= pick ? bus.req1_wdata : bus.req0_wdata;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          if (done) begin
            state_q <= StRelease;
            last_q  <= owner_q;
            if (tmo_hit) err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sram_r_en   = in_busy && (op_q == OP_RD);
  assign bus.sram_w_en   = in_busy && (op_q == OP_WR);
  assign bus.sram_addr   = addr_q;
  assign bus.sram_wdata  = wdata_q;
  assign bus.grant       = in_busy ? port_onehot(owner_q) : 2'b00;
  assign bus.req_ready   = done ? port_onehot(owner_q) : 2'b00;
  assign bus.req_rdata   = (in_busy && bus.sram_ready && (op_q == OP_RD)) ? bus.sram_rdata : '0;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a round-robin and a fixed-priority instance share one
// stimulus engine; a transaction-level model feeds scoreboard queues checked by a monitor.
module tb_sram_arbiter;

  localparam int unsigned TO = 8;

  typedef struct {
    int          cyc;
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } start_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [63:0] rdata;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if if_rr ();
  sram_arbiter_if if_fp ();

  sram_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO)) u_dut_rr (.clk(clk), .rst(rst), .bus(if_rr));
  sram_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TO)) u_dut_fp (.clk(clk), .rst(rst), .bus(if_fp));

  // Driven stimulus, routed to whichever instance is selected.
  logic [1:0]  d_r_en, d_w_en;
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata[2];
  logic        d_srdy;
  logic [63:0] d_srdata;

  assign if_rr.req_r_en   = sel ? 2'b00 : d_r_en;
  assign if_rr.req_w_en   = sel ? 2'b00 : d_w_en;
  assign if_rr.req0_addr  = sel ? 32'h0 : d_addr[0];
  assign if_rr.req1_addr  = sel ? 32'h0 : d_addr[1];
  assign if_rr.req0_wdata = sel ? 32'h0 : d_wdata[0];
  assign if_rr.req1_wdata = sel ? 32'h0 : d_wdata[1];
  assign if_rr.sram_ready = sel ? 1'b0 : d_srdy;
  assign if_rr.sram_rdata = sel ? 64'h0 : d_srdata;
  assign if_fp.req_r_en   = sel ? d_r_en : 2'b00;
  assign if_fp.req_w_en   = sel ? d_w_en : 2'b00;
  assign if_fp.req0_addr  = sel ? d_addr[0] : 32'h0;
  assign if_fp.req1_addr  = sel ? d_addr[1] : 32'h0;
  assign if_fp.req0_wdata = sel ? d_wdata[0] : 32'h0;
  assign if_fp.req1_wdata = sel ? d_wdata[1] : 32'h0;
  assign if_fp.sram_ready = sel ? d_srdy : 1'b0;
  assign if_fp.sram_rdata = sel ? d_srdata : 64'h0;

  logic [1:0]  o_ready, o_grant;
  logic [63:0] o_rdata;
  logic [31:0] o_addr, o_wdata;
  logic        o_ren, o_wen, o_terr;

  assign o_ready = sel ? if_fp.req_ready   : if_rr.req_ready;
  assign o_grant = sel ? if_fp.grant       : if_rr.grant;
  assign o_rdata = sel ? if_fp.req_rdata   : if_rr.req_rdata;
  assign o_addr  = sel ? if_fp.sram_addr   : if_rr.sram_addr;
  assign o_wdata = sel ? if_fp.sram_wdata  : if_rr.sram_wdata;
  assign o_ren   = sel ? if_fp.sram_r_en   : if_rr.sram_r_en;
  assign o_wen   = sel ? if_fp.sram_w_en   : if_rr.sram_w_en;
  assign o_terr  = sel ? if_fp.timeout_err : if_rr.timeout_err;

  int errors = 0;
  int checks = 0;

  start_t exp_q[$];
  done_t  cmp_q[$];

  // Transaction-level model of the shared resource.
  bit          m_act = 1'b0;
  int          m_port = 0;
  bit          m_wr = 1'b0;
  int          m_s0 = 0;
  int          m_delay = 0;
  int          m_last = 1;
  bit          m_err = 1'b0;
  bit          m_fin[2] = '{1'b0, 1'b0};
  bit          post_rst_chk = 1'b0;

  // Requesters' true (unscrambled) requests.
  bit          r_act[2] = '{1'b0, 1'b0};
  int          r_op[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];
  bit          stim_on = 1'b1;
  int          req_pct = 35;
  int          hold_off = 0;
  int          rst_pend = 0;
  bit          rst_done = 1'b0;

  function automatic logic [1:0] oh(int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_evt(string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d actual=event required=none", name, cyc);
  endtask

  // Monitor: steps the model and compares whatever the DUT presents this cycle.
  initial begin
    start_t cur;
    done_t  c;
    bit     prev_en = 1'b0;
    cur = '{0, 0, 1'b0, 32'h0, 32'h0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_enables", {o_wen, o_ren}, 2'b00);
        chk("rst_ready", o_ready, 2'b00);
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_terr", o_terr, 1'b0);
        m_act   = 1'b0;
        m_last  = 1;
        m_err   = 1'b0;
        m_fin   = '{1'b0, 1'b0};
        prev_en = 1'b0;
        exp_q.delete();
        cmp_q.delete();
      end else begin
        bit was_act;
        bit fin;
        bit tmo;
        bit en;
        bit [1:0] r;
        int w;
        was_act = m_act;
        fin     = 1'b0;
        tmo     = 1'b0;
        if (m_act) begin
          if (d_srdy) fin = 1'b1;
          else if (cyc - m_s0 + 1 >= int'(TO)) begin
            fin = 1'b1;
            tmo = 1'b1;
            cmp_q.push_back('{cyc, m_port, 64'h0});
          end
        end

        en = o_ren | o_wen;
        if (en && !prev_en) begin
          if (exp_q.size() == 0) fail_evt("spurious_start");
          else begin
            cur = exp_q.pop_front();
            chk("start_cycle", 64'(cyc), 64'(cur.cyc));
            chk("start_grant", o_grant, oh(cur.port));
            chk("start_addr", o_addr, cur.addr);
            chk("start_wdata", o_wdata, cur.wdata);
            chk("start_op", {o_wen, o_ren}, cur.wr ? 2'b10 : 2'b01);
            if (post_rst_chk) begin
              chk("post_reset_grant", o_grant, 2'b10);
              post_rst_chk = 1'b0;
            end
          end
        end else if (en) begin
          chk("hold_addr", o_addr, cur.addr);
          chk("hold_wdata", o_wdata, cur.wdata);
          chk("hold_op", {o_wen, o_ren}, cur.wr ? 2'b10 : 2'b01);
          chk("hold_grant", o_grant, oh(cur.port));
        end else begin
          chk("idle_grant", o_grant, 2'b00);
        end

        if (o_ready != 2'b00) begin
          if (cmp_q.size() == 0) fail_evt("spurious_ready");
          else begin
            c = cmp_q.pop_front();
            chk("ready_cycle", 64'(cyc), 64'(c.cyc));
            chk("ready_port", o_ready, oh(c.port));
            chk("ready_rdata", o_rdata, c.rdata);
          end
        end else begin
          chk("idle_rdata", o_rdata, 64'h0);
        end
        chk("timeout_err", o_terr, m_err);

        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          fail_evt("missing_start");
          void'(exp_q.pop_front());
        end
        if (cmp_q.size() != 0 && cmp_q[0].cyc < cyc) begin
          fail_evt("missing_ready");
          void'(cmp_q.pop_front());
        end
        prev_en = en;

        if (fin) begin
          m_act         = 1'b0;
          m_last        = m_port;
          m_fin[m_port] = 1'b1;
          if (tmo) m_err = 1'b1;
        end
        if (!was_act) begin
          r = d_r_en | d_w_en;
          if (r != 2'b00) begin
            if (sel) w = r[1] ? 1 : 0;
            else if (r == 2'b11) w = 1 - m_last;
            else w = r[1] ? 1 : 0;
            m_act   = 1'b1;
            m_port  = w;
            m_wr    = d_w_en[w];
            m_s0    = cyc + 1;
            case ($urandom_range(9))
              7:       m_delay = int'(TO);
              8, 9:    m_delay = 100;
              default: m_delay = 1 + int'($urandom_range(6));
            endcase
            exp_q.push_back('{cyc + 1, w, d_w_en[w], d_addr[w], d_wdata[w]});
          end
        end
      end
    end
  end

  task automatic step_requesters();
    if (hold_off > 0) hold_off--;
    for (int p = 0; p < 2; p++) begin
      if (m_fin[p]) begin
        r_act[p] = 1'b0;
        m_fin[p] = 1'b0;
      end else if (!r_act[p] && stim_on && (p == 1 || hold_off == 0) &&
                   $urandom_range(99) < req_pct) begin
        r_act[p]   = 1'b1;
        r_op[p]    = int'($urandom_range(2));  // 0 read, 1 write, 2 both (write wins)
        r_addr[p]  = $urandom;
        r_wdata[p] = $urandom;
      end
    end
  endtask

  task automatic drive(bit no_srdy);
    for (int p = 0; p < 2; p++) begin
      if (m_act && m_port == p && $urandom_range(1) == 1) begin
        d_r_en[p]  = 1'($urandom_range(1));
        d_w_en[p]  = 1'($urandom_range(1));
        d_addr[p]  = $urandom;
        d_wdata[p] = $urandom;
      end else begin
        d_r_en[p]  = r_act[p] && (r_op[p] != 1);
        d_w_en[p]  = r_act[p] && (r_op[p] != 0);
        d_addr[p]  = r_addr[p];
        d_wdata[p] = r_wdata[p];
      end
    end
    d_srdy   = 1'b0;
    d_srdata = {$urandom, $urandom};
    if (!no_srdy) begin
      if (m_act) begin
        if (cyc - m_s0 + 1 == m_delay) begin
          d_srdy = 1'b1;
          cmp_q.push_back('{cyc, m_port, m_wr ? 64'h0 : d_srdata});
        end
      end else if ($urandom_range(7) == 0) begin
        d_srdy = 1'b1;
      end
    end
  endtask

  task automatic run_cycles(int n, bit do_rst);
    bit fire;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rst_pend > 0) begin
        rst_pend--;
        if (rst_pend == 0) rst = 1'b1;
      end
      fire = do_rst && !rst_done && (i > n / 2) && rst && m_act && (cyc - m_s0 >= 1);
      step_requesters();
      if (fire) begin
        r_act[0]   = 1'b0;
        r_act[1]   = 1'b1;
        r_op[1]    = 0;
        r_addr[1]  = 32'h0000_0404;
        r_wdata[1] = $urandom;
        hold_off   = 4;
      end
      drive(fire);
      if (fire) begin
        #2 rst = 1'b0;
        #1;
        chk("async_rst_enables", {o_wen, o_ren}, 2'b00);
        chk("async_rst_ready", o_ready, 2'b00);
        chk("async_rst_grant", o_grant, 2'b00);
        chk("async_rst_rdata", o_rdata, 64'h0);
        rst_done     = 1'b1;
        rst_pend     = 2;
        post_rst_chk = 1'b1;
      end
    end
  endtask

  initial begin
    d_r_en = 2'b00; d_w_en = 2'b00; d_srdy = 1'b0; d_srdata = 64'h0;
    for (int p = 0; p < 2; p++) begin
      d_addr[p] = 32'h0; d_wdata[p] = 32'h0;
      r_op[p] = 0; r_addr[p] = 32'h0; r_wdata[p] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_cycles(1200, 1'b1);
    if (!rst_done) fail_evt("reset_abort_not_reached");
    stim_on = 1'b0;
    run_cycles(60, 1'b0);

    @(posedge clk);
    #1 rst = 1'b0;
    sel      = 1'b1;
    r_act[0] = 1'b0;
    r_act[1] = 1'b0;
    drive(1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    stim_on = 1'b1;
    req_pct = 80;
    run_cycles(800, 1'b0);
    stim_on = 1'b0;
    run_cycles(60, 1'b0);

    chk("start_queue_drained", 64'(exp_q.size()), 64'h0);
    chk("ready_queue_drained", 64'(cmp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
